// File: rtl/mult_add_acc_pipe.sv
// Pipelined unsigned a*b+c with in-place running accumulation, valid and last tracking.
// Optional sticky overflow flag and port enabled by defining MULT_ADD_OVF_EN.
module mult_add_acc_pipe #(
    parameter int unsigned WIDTH   = 18,
    parameter int unsigned LATENCY = 3,
    parameter int unsigned GUARD   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ce,
    input  logic                        sclr,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            a,
    input  logic [WIDTH-1:0]            b,
    input  logic [WIDTH-1:0]            c,
    input  logic                        acc_en,
    input  logic                        acc_first,
    input  logic                        in_last,
    output logic                        out_valid,
    output logic [2*WIDTH+GUARD-1:0]    p,
    output logic                        out_last
`ifdef MULT_ADD_OVF_EN
    ,
    output logic                        ovf
`endif
);

    localparam int unsigned PW    = 2 * WIDTH + GUARD;
    localparam int unsigned MW    = 2 * WIDTH;
    localparam int unsigned DEPTH = LATENCY - 1;
    localparam int unsigned LS    = DEPTH - 1;
`ifdef MULT_ADD_OVF_EN
    localparam int unsigned SW    = PW + 1;
`else
    localparam int unsigned SW    = PW;
`endif

    logic [MW-1:0]    prod_q [DEPTH];
    logic [WIDTH-1:0] c_q    [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] acc_en_q;
    logic [DEPTH-1:0] acc_first_q;
    logic [DEPTH-1:0] last_q;

    logic [MW-1:0]    prod_c;
    logic [PW-1:0]    addend_c;
    logic [SW-1:0]    sum_c;
    logic             seed_c;

    assign prod_c = MW'(a) * MW'(b);

    // Product and control delay line, stages 1..LATENCY-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                prod_q[i] <= '0;
                c_q[i]    <= '0;
            end
            vld_q       <= '0;
            acc_en_q    <= '0;
            acc_first_q <= '0;
            last_q      <= '0;
        end else if (sclr) begin
            vld_q <= '0;
        end else if (ce) begin
            prod_q[0]      <= prod_c;
            c_q[0]         <= c;
            vld_q[0]       <= in_valid;
            acc_en_q[0]    <= acc_en;
            acc_first_q[0] <= acc_first;
            last_q[0]      <= in_last;
            for (int i = 1; i < int'(DEPTH); i++) begin
                prod_q[i]      <= prod_q[i-1];
                c_q[i]         <= c_q[i-1];
                vld_q[i]       <= vld_q[i-1];
                acc_en_q[i]    <= acc_en_q[i-1];
                acc_first_q[i] <= acc_first_q[i-1];
                last_q[i]      <= last_q[i-1];
            end
        end
    end

    // Final-stage adder: feedback from p only when continuing an accumulation
    always_comb begin
        seed_c   = !acc_en_q[LS] || acc_first_q[LS];
        addend_c = seed_c ? PW'(c_q[LS]) : p;
        sum_c    = SW'(prod_q[LS]) + SW'(addend_c);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (sclr) begin
            p         <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (ce) begin
            out_valid <= vld_q[LS];
            out_last  <= vld_q[LS] & last_q[LS];
            if (vld_q[LS]) begin
                p <= sum_c[PW-1:0];
            end
        end
    end

`ifdef MULT_ADD_OVF_EN
    // Sticky carry-out; a seeded result restarts it from its own carry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (sclr) begin
            ovf <= 1'b0;
        end else if (ce && vld_q[LS]) begin
            ovf <= seed_c ? sum_c[PW] : (ovf | sum_c[PW]);
        end
    end
`endif

endmodule

// File: doc/mult_add_acc_pipe.md
# mult_add_acc_pipe

Parametrised, pipelined unsigned multiply-add with an optional running-accumulate mode, valid tracking and last-flag pass-through. This is the next-generation multiply-add slice for the cp_cluster datapath. It generalises the fixed 18-bit single-cycle a*b+c block to any operand width, a configurable pipeline depth, and guard bits for accumulation. Sequences of products can be summed in place without external feedback.

## Interface
- WIDTH, 18, operand width of a, b and c.
- LATENCY, 3, cycles from input sample to registered output. Legal range 2..8.
- GUARD, 4, extra result MSBs for accumulation headroom. Legal range 0..8.
- PW (localparam), 2*WIDTH+GUARD, result width.

- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- ce  in  1  clock enable. When 0, the entire pipeline holds.
- sclr  in  1  synchronous clear. Priority over ce.
- in_valid  in  1  a/b/c/acc_en/acc_first/in_last are valid this cycle.
- a  in  WIDTH  multiplicand, unsigned.
- b  in  WIDTH  multiplier, unsigned.
- c  in  WIDTH  addend or accumulation seed, unsigned.
- acc_en  in  1  0 = independent a*b+c; 1 = accumulate mode.
- acc_first  in  1  accumulate mode only: seed with c instead of the previous p.
- in_last  in  1  tag forwarded to out_last.
- out_valid  out  1  p/out_last are valid.
- p  out  PW  result.
- out_last  out  1  delayed in_last.
- ovf  out  1  sticky overflow. Present only with MULT_ADD_OVF_EN.

## Operation
- Sample point: a cycle with ce=1 and in_valid=1. Samples with in_valid=0 are bubbles and advance as invalid.
- Product path: a*b is computed and registered over stages 1..LATENCY-1. Retiming across these stages is allowed. Operands are zero-extended.
- Final stage (stage LATENCY) holds the only adder. On a valid sample it computes:
  - acc_en=0: p = a*b + c.
  - acc_en=1, acc_first=1: p = a*b + c.
  - acc_en=1, acc_first=0: p = a*b + p, where p is the current output register, i.e. the last valid result.
- The addition is modulo 2^PW. Invalid samples leave p unchanged.
- acc_first is ignored when acc_en=0.
- acc_en=1, acc_first=0 as the first sample after reset or sclr adds to p=0.
- Control fields (acc_en, acc_first, in_last, valid) are delayed alongside the product.

## Timing
- Reset values (rst or sclr): p=0, out_valid=0, out_last=0, ovf=0, and all internal valid bits 0. rst acts immediately; sclr acts at the next edge.
- Latency: a sample taken at edge N appears with out_valid=1 after edge N+LATENCY, counting only ce=1 edges.
- Throughput: one sample per cycle, including back-to-back accumulation. The feedback spans only the final stage, so no stall is needed.
- out_valid is high for exactly one ce=1 cycle per sample. It holds its value while ce=0.
- ce=0: every register holds, including out_valid, p and ovf. Inputs are ignored.
- Reset mid-operation: all in-flight samples are discarded and no out_valid is produced for them. The first sample after reset sees p=0.
- sclr and ce=0 in the same cycle: sclr wins.

## Configuration
- MULT_ADD_OVF_EN defined:
  - Port ovf exists.
  - ovf is set when a final-stage add carries out of bit PW-1.
  - It stays set until rst, sclr, or a valid final-stage result with acc_en=0 or acc_first=1 that does not itself overflow.
  - p still wraps.
- Undefined: the ovf port and its logic are absent, and p wraps silently.

## Test plan
- Basic, WIDTH=18, LATENCY=3: a=3, b=5, c=7, acc_en=0 at cycle 0 -> out_valid=1 and p=22 after 3 edges. The following cycle has out_valid=0 and p holds 22.
- Streaming: 10 consecutive samples a=i, b=i+1, c=i for i=0..9, in_last on i=9 -> 10 consecutive out_valid cycles, p=i*(i+1)+i, out_last only on the 10th.
- Accumulate: first sample (a=2, b=3, c=10, acc_first=1), then (4,5,x), then (6,7,x) with acc_first=0, back-to-back -> p=16, 36, 78 on consecutive cycles.
- ce/sclr: ce=0 for 4 cycles mid-stream -> outputs freeze and no sample is lost or duplicated. Assert sclr with 2 samples in flight -> p=0, and no out_valid for those samples.
- Async reset: rst pulsed between edges -> p and out_valid go to 0 before the next edge, and the pipeline restarts cleanly.
- Overflow (MULT_ADD_OVF_EN, GUARD=4): a=b=2^18-1, acc_first=1 with c=0, then 16 accumulate samples.
  - ovf=0 through the 16th result and =1 on the 17th. p wraps to (17*(2^18-1)^2) mod 2^40.
  - A following acc_en=0 sample with a=1, b=1, c=0 clears ovf.
